// File: rtl/phase_a_iter_ctrl.sv
// Iterates the phase_a step engine ITER times on a SIZE-bit operand; done at s + ITER*(Ls+1) + 1.
// No backpressure: start is taken only in IDLE, a watchdog aborts a WAIT that outlives TIMEOUT.
module phase_a_iter_ctrl #(
  parameter int SIZE    = 3072,
  parameter int RADIX   = 78,
  parameter int ITER    = (SIZE + RADIX - 1) / RADIX,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a_in,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [SIZE-1:0] result,
  output logic            step_en,
  output logic [SIZE-1:0] step_a,
  input  logic [SIZE-1:0] step_new_a,
  input  logic            step_done
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN, S_ERR} state_t;

  localparam logic [CNT_W-1:0] ITER_LAST  = CNT_W'(ITER - 1);
  localparam logic [7:0]       WDOG_LIMIT = 8'(TIMEOUT);

  state_t          state;
  state_t          next_state;
  logic [SIZE-1:0] opnd;
  logic [CNT_W-1:0] iter;
  logic [7:0]      wdog;
  logic            last_step;
  logic            wdog_expire;
  logic            busy_d;
  logic            done_d;
  logic            step_en_d;

  assign last_step   = (iter == ITER_LAST);
  assign wdog_expire = ((wdog + 8'd1) == WDOG_LIMIT);
  assign step_a      = opnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A completing step takes priority over a watchdog expiring in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT: begin
        if (step_done) begin
          next_state = last_step ? S_FIN : S_LAUNCH;
        end else if (wdog_expire) begin
          next_state = S_ERR;
        end
      end
      S_FIN:    next_state = S_IDLE;
      S_ERR:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = (next_state != S_IDLE);
    done_d    = (next_state == S_FIN);
    step_en_d = (next_state == S_LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      step_en <= 1'b0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      step_en <= step_en_d;
    end
  end

  // The operand only moves on an accepted start or a completed step, so it is
  // stable across the engine's whole sampling window after each launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd   <= '0;
      iter   <= '0;
      wdog   <= '0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opnd <= a_in;
            iter <= '0;
            err  <= 1'b0;
          end
        end
        S_LAUNCH: wdog <= '0;
        S_WAIT: begin
          if (step_done) begin
            opnd <= step_new_a;
            if (last_step) begin
              result <= step_new_a;
            end else begin
              iter <= iter + CNT_W'(1);
            end
          end else begin
            wdog <= wdog + 8'd1;
            if (wdog_expire) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_iter_ctrl.sv
// Bench for phase_a_iter_ctrl: two instances (ITER=40/TIMEOUT=20 and ITER=3) driven by behavioural step engines.
module tb_phase_a_iter_ctrl;

  localparam int SIZE = 3072;
  localparam int IT0  = 40;
  localparam int IT1  = 3;
  localparam int NVEC = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      start = '0;
  logic [SIZE-1:0] a_in [2];
  logic [1:0]      busy, done, err, step_en;
  logic [1:0]      step_done = '0;
  logic [SIZE-1:0] result [2];
  logic [SIZE-1:0] step_a [2];
  logic [SIZE-1:0] step_new_a [2];

  phase_a_iter_ctrl #(.SIZE(SIZE), .ITER(IT0), .CNT_W(6), .TIMEOUT(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_in(a_in[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .result(result[0]), .step_en(step_en[0]),
    .step_a(step_a[0]), .step_new_a(step_new_a[0]), .step_done(step_done[0]));

  phase_a_iter_ctrl #(.SIZE(SIZE), .ITER(IT1), .CNT_W(6), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_in(a_in[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .result(result[1]), .step_en(step_en[1]),
    .step_a(step_a[1]), .step_new_a(step_new_a[1]), .step_done(step_done[1]));

  always #5 clk = ~clk;

  // Step engine behaviour: 0 increment, 1 rotate left, 2 xor-shift-add.
  function automatic logic [SIZE-1:0] stub_f(input int mode, input logic [SIZE-1:0] a);
    case (mode)
      0:       return a + SIZE'(1);
      1:       return {a[SIZE-2:0], a[SIZE-1]};
      default: return (a ^ (a << 5)) + SIZE'(40503);
    endcase
  endfunction

  function automatic logic [SIZE-1:0] model_run(input int mode, input logic [SIZE-1:0] a, input int n);
    logic [SIZE-1:0] v;
    v = a;
    for (int k = 0; k < n; k++) v = stub_f(mode, v);
    return v;
  endfunction

  int md [2] = '{0, 0};
  int lsv [2] = '{1, 1};
  int cnt [2] = '{0, 0};
  int launches [2] = '{0, 0};
  int stab_viol [2] = '{0, 0};
  int dbl_en [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic [1:0] prev_en = '0;
  logic [SIZE-1:0] cap [2];
  logic [SIZE-1:0] sa_pre [2];
  logic [1:0] upd_ok = '0;
  bit chk_stab = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      sa_pre[i] = step_a[i];
      upd_ok[i] = step_done[i] | start[i];
    end
  end

  // Engine model: step_done arrives Ls cycles after the step_en cycle (Ls=0 means never).
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      step_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          step_done[i] = 1'b1;
          step_new_a[i] = stub_f(md[i], step_a[i]);
          if (step_a[i] !== cap[i]) stab_viol[i]++;
        end
      end
      if (step_en[i] === 1'b1) begin
        if (prev_en[i]) dbl_en[i]++;
        launches[i]++;
        cap[i] = step_a[i];
        if (lsv[i] > 0) cnt[i] = lsv[i];
      end
      prev_en[i] = step_en[i];
      if (done[i] === 1'b1) done_cnt[i]++;
      if (chk_stab && (step_a[i] !== sa_pre[i]) && !upd_ok[i]) stab_viol[i]++;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h expected low64 %h", nm, got[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input int i, input logic [SIZE-1:0] a, input int mode, input int ls,
                        output logic [SIZE-1:0] res, output int lat, output logic er,
                        output int la, output int sv, output int de);
    int s, at, l0, v0, d0;
    md[i] = mode;
    lsv[i] = ls;
    l0 = launches[i]; v0 = stab_viol[i]; d0 = dbl_en[i];
    tick();
    a_in[i] = a;
    start[i] = 1'b1;
    s = cyc;
    tick();
    start[i] = 1'b0;
    wait_done(i, 3000, at);
    lat = (at < 0) ? -1 : at - s;
    res = result[i];
    er = err[i];
    la = launches[i] - l0;
    sv = stab_viol[i] - v0;
    de = dbl_en[i] - d0;
  endtask

  typedef struct {
    int              sel;
    logic [SIZE-1:0] a;
    int              mode;
    int              ls;
    logic [SIZE-1:0] exp_res;
    int              exp_lat;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    logic [SIZE-1:0] res, msb, ra;
    int lat, la, sv, de, s, at1, at2, l0, d0;
    logic er;

    a_in[0] = '0; a_in[1] = '0;
    step_new_a[0] = '0; step_new_a[1] = '0;
    msb = '0;
    msb[SIZE-1] = 1'b1;

    tbl[0] = '{0, SIZE'(5), 0, 17, SIZE'(45), 721};
    tbl[1] = '{1, msb, 1, 17, SIZE'(4), 55};
    tbl[2] = '{1, msb, 1, 1, SIZE'(4), 7};
    tbl[3] = '{0, SIZE'(5), 0, 20, SIZE'(45), 841};
    for (int k = 4; k < NVEC; k++) begin
      ra = '0;
      for (int w = 0; w < SIZE / 32; w++) ra[w*32 +: 32] = $urandom;
      tbl[k].sel = int'($urandom_range(0, 1));
      tbl[k].a = ra;
      tbl[k].mode = int'($urandom_range(0, 2));
      tbl[k].ls = int'($urandom_range(1, 19));
      tbl[k].exp_res = model_run(tbl[k].mode, ra, tbl[k].sel ? IT1 : IT0);
      tbl[k].exp_lat = (tbl[k].sel ? IT1 : IT0) * (tbl[k].ls + 1) + 1;
    end

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d busy", i), 64'(busy[i]), 0);
      chk($sformatf("rst%0d done", i), 64'(done[i]), 0);
      chk($sformatf("rst%0d err", i), 64'(err[i]), 0);
      chk($sformatf("rst%0d step_en", i), 64'(step_en[i]), 0);
      chk_v($sformatf("rst%0d result", i), result[i], '0);
      chk_v($sformatf("rst%0d step_a", i), step_a[i], '0);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    chk_stab = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      run_op(tbl[k].sel, tbl[k].a, tbl[k].mode, tbl[k].ls, res, lat, er, la, sv, de);
      chk_v($sformatf("vec%0d result", k), res, tbl[k].exp_res);
      chk($sformatf("vec%0d latency", k), 64'(lat), 64'(tbl[k].exp_lat));
      chk($sformatf("vec%0d err", k), 64'(er), 0);
      chk($sformatf("vec%0d launches", k), 64'(la), tbl[k].sel ? IT1 : IT0);
      chk($sformatf("vec%0d step_a stability", k), 64'(sv), 0);
      chk($sformatf("vec%0d back-to-back step_en", k), 64'(de), 0);
    end

    // Engine never answers: watchdog fires 21 cycles after LAUNCH.
    md[0] = 0; lsv[0] = 0;
    d0 = done_cnt[0];
    tick();
    a_in[0] = SIZE'(7); start[0] = 1'b1; s = cyc;
    tick();
    start[0] = 1'b0;
    while (cyc < s + 21) tick();
    chk("timeout err before limit", 64'(err[0]), 0);
    tick();
    chk("timeout err set", 64'(err[0]), 1);
    chk("timeout busy in ERR", 64'(busy[0]), 1);
    tick();
    chk("timeout busy after ERR", 64'(busy[0]), 0);
    chk("timeout err sticky", 64'(err[0]), 1);
    chk("timeout no done", 64'(done_cnt[0] - d0), 0);
    lsv[0] = 3;
    tick();
    a_in[0] = SIZE'(100); start[0] = 1'b1; s = cyc;
    tick();
    start[0] = 1'b0;
    chk("start clears err", 64'(err[0]), 0);
    wait_done(0, 3000, at1);
    chk_v("after timeout result", result[0], SIZE'(140));

    // Late step_done arrives while in ERR and must not touch the operand.
    lsv[0] = 21;
    l0 = launches[0]; d0 = done_cnt[0];
    tick();
    a_in[0] = SIZE'(9); start[0] = 1'b1; s = cyc;
    tick();
    start[0] = 1'b0;
    while (cyc < s + 25) tick();
    chk("late done err", 64'(err[0]), 1);
    chk_v("late done ignored", step_a[0], SIZE'(9));
    chk("late done launches", 64'(launches[0] - l0), 1);
    chk("late done no done", 64'(done_cnt[0] - d0), 0);

    // start held through the whole operation with a_in changed mid-run.
    lsv[0] = 3;
    tick();
    a_in[0] = SIZE'(256); start[0] = 1'b1; s = cyc;
    repeat (50) tick();
    a_in[0] = SIZE'(512);
    wait_done(0, 3000, at1);
    chk("hold first latency", 64'(at1 - s), 161);
    chk_v("hold first result", result[0], SIZE'(296));
    tick();
    chk("hold idle gap busy", 64'(busy[0]), 0);
    tick();
    chk("hold restart busy", 64'(busy[0]), 1);
    start[0] = 1'b0;
    wait_done(0, 3000, at2);
    chk("hold second latency", 64'(at2 - (at1 + 1)), 161);
    chk_v("hold second result", result[0], SIZE'(552));

    // Reset pulled during the 10th WAIT; the engine's pending step_done lands afterwards.
    md[0] = 0; lsv[0] = 17;
    l0 = launches[0]; d0 = done_cnt[0];
    tick();
    a_in[0] = SIZE'(5); start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 2000 && (launches[0] - l0) < 10; c++) tick();
    repeat (5) tick();
    chk_stab = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst busy", 64'(busy[0]), 0);
    chk("midrst err", 64'(err[0]), 0);
    chk("midrst step_en", 64'(step_en[0]), 0);
    chk_v("midrst result", result[0], '0);
    chk_v("midrst step_a", step_a[0], '0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk_v("midrst late step_a", step_a[0], '0);
    chk("midrst late busy", 64'(busy[0]), 0);
    chk("midrst late done", 64'(done_cnt[0] - d0), 0);
    chk("midrst launches", 64'(launches[0] - l0), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
